hdmi_timing_gen: RTL

Free-running HDMI raster timing generator: produces the `hdmi_cx`/`hdmi_cy` coordinates compared by the VDP-to-HDMI sync stage, plus registered `hsync`, `vsync` and `de` for the TMDS encoder. It consumes `ff_video_reset` from that stage to re-phase its raster to 0,0 and reports a frame-lock status derived from how often re-phasing occurs.

---
 rtl/hdmi_timing_gen_pkg.sv | 35 +++
 rtl/hdmi_lock_monitor.sv | 77 +++++++
 rtl/hdmi_timing_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hdmi_timing_gen_pkg.sv
// Shared 480p raster defaults, counter widths and small decode helpers for
// the HDMI timing generator and its lock monitor.
package hdmi_timing_gen_pkg;

    // Default 720x480p60 timing
    localparam int DEF_H_ACTIVE = 720;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 62;
    localparam int DEF_H_BP     = 60;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 9;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 30;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_LOCK_FRAMES = 4;

    // Counter widths shared with the sync stage
    localparam int CX_W = 12;
    localparam int CY_W = 11;
    localparam int FC_W = 3;
    localparam int RC_W = 8;

    localparam int CX_MAX_TOTAL = 1 << CX_W;
    localparam int CY_MAX_TOTAL = 1 << CY_W;
    localparam int FC_MAX       = (1 << FC_W) - 1;

    // Drive the sync line to its active level inside the window, idle otherwise
    function automatic logic sync_level(input logic in_window, input logic pol);
        return in_window ? pol : ~pol;
    endfunction

endpackage

// File: rtl/hdmi_lock_monitor.sv
// Frame-lock monitor: counts clean (natural) raster wraps, declares lock after
// LOCK_FRAMES of them, drops lock on any re-phase, and counts re-phase cycles.
module hdmi_lock_monitor
    import hdmi_timing_gen_pkg::*;
#(
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            natural_wrap_i,
    input  logic            video_reset_i,
    output logic            locked_o,
    output logic [RC_W-1:0] resync_count_o
);

    typedef enum logic {
        LS_HUNTING = 1'b0,
        LS_LOCKED  = 1'b1
    } lock_state_e;

    localparam logic [FC_W-1:0] FC_TARGET = FC_W'(LOCK_FRAMES);
    localparam logic [RC_W-1:0] RC_SAT    = {RC_W{1'b1}};

    lock_state_e     state_q, state_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic [RC_W-1:0] rc_q, rc_d;

    // State, frame counter and resync counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= LS_HUNTING;
            fc_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            rc_q    <= rc_d;
        end
    end

    // Next state: a re-phase always wins over a wrap in the same cycle, so a
    // video_reset that lands on the wrap point is never counted as clean.
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        rc_d    = rc_q;
        if (video_reset_i) begin
            state_d = LS_HUNTING;
            fc_d    = '0;
            if (rc_q != RC_SAT) begin
                rc_d = rc_q + 1'b1;
            end
        end else begin
            case (state_q)
                LS_HUNTING: begin
                    if (natural_wrap_i) begin
                        fc_d = fc_q + 1'b1;
                        if (fc_d == FC_TARGET) begin
                            state_d = LS_LOCKED;
                        end
                    end
                end
                LS_LOCKED: begin
                    state_d = LS_LOCKED;
                end
                default: begin
                    state_d = LS_HUNTING;
                    fc_d    = '0;
                end
            endcase
        end
    end

    assign locked_o       = (state_q == LS_LOCKED);
    assign resync_count_o = rc_q;

endmodule

// File: rtl/hdmi_timing_gen.sv
// Free-running HDMI raster generator. Produces column/line coordinates plus
// registered de/hsync/vsync/frame_start decoded from the next coordinates, so
// every output describes the same pixel as hdmi_cx_o/hdmi_cy_o.
module hdmi_timing_gen
    import hdmi_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic H_SYNC_POL  = 1'b0,
    parameter logic V_SYNC_POL  = 1'b0,
    parameter int   LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            video_reset_i,
    output logic [CX_W-1:0] hdmi_cx_o,
    output logic [CY_W-1:0] hdmi_cy_o,
    output logic            de_o,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            frame_start_o,
    output logic            locked_o,
    output logic [RC_W-1:0] resync_count_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > CX_MAX_TOTAL) begin : g_h_total_too_big
        $error("hdmi_timing_gen: H_TOTAL exceeds 12-bit column counter");
    end
    if (V_TOTAL > CY_MAX_TOTAL) begin : g_v_total_too_big
        $error("hdmi_timing_gen: V_TOTAL exceeds 11-bit line counter");
    end
    if (LOCK_FRAMES < 1 || LOCK_FRAMES > FC_MAX) begin : g_lock_frames_bad
        $error("hdmi_timing_gen: LOCK_FRAMES must be 1..7");
    end

    // Inclusive bounds keep every constant within the counter width even
    // when a total sits exactly at the 4096/2048 limit.
    localparam logic [CX_W-1:0] H_LAST     = CX_W'(H_TOTAL - 1);
    localparam logic [CX_W-1:0] H_ACT_LAST = CX_W'(H_ACTIVE - 1);
    localparam logic [CX_W-1:0] HS_FIRST   = CX_W'(H_ACTIVE + H_FP);
    localparam logic [CX_W-1:0] HS_LAST    = CX_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CY_W-1:0] V_LAST     = CY_W'(V_TOTAL - 1);
    localparam logic [CY_W-1:0] V_ACT_LAST = CY_W'(V_ACTIVE - 1);
    localparam logic [CY_W-1:0] VS_FIRST   = CY_W'(V_ACTIVE + V_FP);
    localparam logic [CY_W-1:0] VS_LAST    = CY_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CX_W-1:0] cx_q, cx_d;
    logic [CY_W-1:0] cy_q, cy_d;
    logic            de_q, de_d;
    logic            hs_q, hs_d;
    logic            vs_q, vs_d;
    logic            fs_q, fs_d;
    logic            line_end;
    logic            natural_wrap;

    // Next coordinates and the decode of those coordinates
    always_comb begin
        line_end     = (cx_q == H_LAST);
        natural_wrap = line_end && (cy_q == V_LAST);
        cx_d         = cx_q + 1'b1;
        cy_d         = cy_q;
        if (video_reset_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (line_end) begin
            cx_d = '0;
            cy_d = natural_wrap ? '0 : cy_q + 1'b1;
        end
        de_d = (cx_d <= H_ACT_LAST) && (cy_d <= V_ACT_LAST);
        hs_d = sync_level((cx_d >= HS_FIRST) && (cx_d <= HS_LAST), H_SYNC_POL);
        vs_d = sync_level((cy_d >= VS_FIRST) && (cy_d <= VS_LAST), V_SYNC_POL);
        fs_d = (cx_d == '0) && (cy_d == '0);
    end

    // Raster and decoded-output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cx_q <= '0;
            cy_q <= '0;
            de_q <= 1'b0;
            hs_q <= ~H_SYNC_POL;
            vs_q <= ~V_SYNC_POL;
            fs_q <= 1'b0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            fs_q <= fs_d;
        end
    end

    hdmi_lock_monitor #(
        .LOCK_FRAMES(LOCK_FRAMES)
    ) u_lock_monitor (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .natural_wrap_i (natural_wrap),
        .video_reset_i  (video_reset_i),
        .locked_o       (locked_o),
        .resync_count_o (resync_count_o)
    );

    assign hdmi_cx_o     = cx_q;
    assign hdmi_cy_o     = cy_q;
    assign de_o          = de_q;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign frame_start_o = fs_q;

endmodule
